// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes the external bit/word clocks into clkin, deserializes 16-bit L/R words, queues {left,right} frames in a FWFT FIFO.
// Latency: a frame is pushed 1 clkin cycle after the sclk edge that captures its right word (about 4 clkin cycles after the sclk_in rise).
// Backpressure: none toward the I2S source; a frame that arrives while the FIFO is full is dropped and sets sticky ovf (a same-cycle rd_en avoids the drop).
//
// Ports: clkin/reset (sync, active-high); sclk_in, lrck_in, sdin (async serial inputs); rx_en gates pushes;
//        rd_en pops; dout/empty/level FIFO head and status; ovf/ovf_clr sticky overflow;
//        peak_l/peak_r/peak_clr per-channel peak magnitude, present only when I2S_RX_PEAK_EN is defined.
module i2s_rx #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clkin,
    input  logic                  reset,
    input  logic                  sclk_in,
    input  logic                  lrck_in,
    input  logic                  sdin,
    input  logic                  rx_en,
    input  logic                  rd_en,
    output logic [31:0]           dout,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic [14:0]           peak_l,
    output logic [14:0]           peak_r,
    input  logic                  peak_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;

    // ---------------- synchronizers and edge detection ----------------
    logic [2:0]  sclk_s, lrck_s, sdin_s;
    logic [1:0]  fill;        // counts cycles since reset until the sync chains hold real samples
    logic        sync_ok, sclk_rise, lr_edge, bit_in;

    // Edges are ignored while the chains still hold reset zeros, so a line
    // that is already high at reset release is not mistaken for an edge.
    assign sync_ok   = (fill == 2'd3);
    assign sclk_rise = sync_ok & sclk_s[1] & ~sclk_s[2];
    assign lr_edge   = sync_ok & (lrck_s[1] ^ lrck_s[2]);
    assign bit_in    = sdin_s[2];

    // ---------------- deserializer state ----------------
    logic [15:0] shreg, left_word, word;
    logic        armed, arm_rise, in_sync, left_vld;
    logic        cap_l, cap_r;
    logic        push_req;
    logic [31:0] push_dat;

    assign word  = {shreg[14:0], bit_in};
    assign cap_l = sclk_rise & armed & ~arm_rise;   // word that ended with lrck high
    assign cap_r = sclk_rise & armed &  arm_rise;   // word that ended with lrck low

    always_ff @(posedge clkin) begin
        if (reset) begin
            sclk_s    <= '0;
            lrck_s    <= '0;
            sdin_s    <= '0;
            fill      <= '0;
            shreg     <= '0;
            armed     <= 1'b0;
            arm_rise  <= 1'b0;
            in_sync   <= 1'b0;
            left_vld  <= 1'b0;
            left_word <= '0;
            push_req  <= 1'b0;
            push_dat  <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk_in};
            lrck_s <= {lrck_s[1:0], lrck_in};
            sdin_s <= {sdin_s[1:0], sdin};
            if (!sync_ok)
                fill <= fill + 2'd1;

            // The capturing bit is the last bit of the old word; clearing
            // afterwards zero-pads a short next word in its MSBs.
            if (sclk_rise)
                shreg <= armed ? 16'h0000 : word;

            if (sclk_rise && armed)
                armed <= 1'b0;
            if (lr_edge) begin
                armed    <= 1'b1;
                arm_rise <= lrck_s[1];
            end

            // A right capture marks the start of a left word that is known to
            // begin after reset, so only frames from here on are trusted.
            if (cap_r)
                in_sync <= 1'b1;

            if (cap_l)
                left_word <= word;
            if (!rx_en)
                left_vld <= 1'b0;
            else if (cap_l)
                left_vld <= in_sync;
            else if (cap_r)
                left_vld <= 1'b0;

            push_req <= cap_r & left_vld & rx_en;
            push_dat <= {left_word, word};
        end
    end

    // ---------------- frame FIFO (first-word fall-through) ----------------
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  full, do_pop, do_push, ovf_set;

    assign empty   = (level == '0);
    assign full    = level[DEPTH_LOG2];
    assign do_pop  = rd_en & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_req & (~full | do_pop);
    assign ovf_set = push_req & full & ~do_pop;
    assign dout    = empty ? 32'h0 : mem[rd_ptr];

    always_ff @(posedge clkin) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            // A new overflow wins over a same-cycle clear.
            ovf <= (ovf & ~ovf_clr) | ovf_set;
        end
    end

    // ---------------- optional peak meters ----------------
`ifdef I2S_RX_PEAK_EN
    // Magnitude of a two's-complement sample; 0x8000 saturates to 0x7FFF.
    function automatic logic [14:0] mag(input logic [15:0] w);
        logic [15:0] n;
        n = -w;
        if (!w[15])
            return w[14:0];
        else if (w == 16'h8000)
            return 15'h7fff;
        else
            return n[14:0];
    endfunction

    always_ff @(posedge clkin) begin
        if (reset || peak_clr) begin
            peak_l <= '0;
            peak_r <= '0;
        end else begin
            if (cap_l && (mag(word) > peak_l))
                peak_l <= mag(word);
            if (cap_r && (mag(word) > peak_r))
                peak_r <= mag(word);
        end
    end
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_l = '0;
    assign peak_r = '0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

    logic        clkin = 1'b0;
    logic        reset, sclk_in, lrck_in, sdin, rx_en, rd_en, ovf_clr, peak_clr;
    logic [31:0] dout;
    logic        empty, ovf;
    logic [4:0]  level;
    logic [14:0] peak_l, peak_r;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        rd_at_rise = 1'b0;
    logic [4:0]  lvl_p3, lvl_p4;
    int          rx_low_slot = -1;
    logic        prev_lsb = 1'b0;

    always #5 clkin = ~clkin;

    i2s_rx #(.DEPTH_LOG2(4)) dut (
        .clkin(clkin), .reset(reset), .sclk_in(sclk_in), .lrck_in(lrck_in), .sdin(sdin),
        .rx_en(rx_en), .rd_en(rd_en), .dout(dout), .empty(empty), .level(level),
        .ovf(ovf), .ovf_clr(ovf_clr), .peak_l(peak_l), .peak_r(peak_r), .peak_clr(peak_clr)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One sclk period: 8 clkin low, 8 clkin high. Level is sampled after the
    // 3rd (capture) and 4th (push) clkin edges following the sclk rise.
    task automatic sclk_cycle(input logic lr, input logic d);
        sclk_in = 1'b0; lrck_in = lr; sdin = d;
        tick(8);
        sclk_in = 1'b1;
        tick(3);
        lvl_p3 = level;
        rd_en  = rd_at_rise;
        tick(1);
        lvl_p4 = level;
        rd_en  = 1'b0;
        tick(4);
    endtask

    // 32 sclk per lrck period, data delayed one bit after each lrck change.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        logic d;
        for (int i = 0; i < 32; i++) begin
            if (i == rx_low_slot) rx_en = 1'b0;
            else if (i == rx_low_slot + 1) rx_en = 1'b1;
            if (i == 0)       d = prev_lsb;
            else if (i <= 16) d = l[16 - i];
            else              d = r[32 - i];
            sclk_cycle(i < 16, d);
        end
        prev_lsb = r[0];
    endtask

    // Extra slot after a frame so its right word gets its capture edge.
    task automatic flush();
        sclk_cycle(1'b1, prev_lsb);
    endtask

    initial begin
        reset = 1'b1; sclk_in = 1'b0; lrck_in = 1'b0; sdin = 1'b0;
        rx_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; peak_clr = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(2);

        // reset state
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_peak_l", peak_l, 0);
        chk("rst_peak_r", peak_r, 0);

        // basic frame and push timing
        rx_en = 1'b1;
        send_frame(16'h1234, 16'hABCD);
        flush();
        chk("push_lvl_at_capture", lvl_p3, 0);
        chk("push_lvl_one_later", lvl_p4, 1);
        chk("basic_dout", dout, 32'h1234ABCD);
        chk("basic_empty", empty, 0);
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        chk("pop_empty", empty, 1);
        chk("pop_level", level, 0);
        chk("pop_dout", dout, 0);

        // rx_en dropped mid-frame discards that frame
        rx_low_slot = 20;
        send_frame(16'h5555, 16'h6666);
        rx_low_slot = -1;
        flush();
        chk("rxen_drop_level", level, 0);

        // 17 frames, no reads: 16 kept, last one overflows
        for (int k = 1; k <= 17; k++)
            send_frame(16'h0100 + 16'(k), 16'h0200 + 16'(k));
        flush();
        chk("full_level", level, 16);
        chk("full_ovf", ovf, 1);
        chk("full_head", dout, 32'h01010201);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        chk("ovf_clr_level", level, 16);

        // full FIFO with rd_en in the push cycle
        send_frame(16'h0F0F, 16'hF0F0);
        rd_at_rise = 1'b1;
        flush();
        rd_at_rise = 1'b0;
        chk("pushpop_lvl_capture", lvl_p3, 16);
        chk("pushpop_lvl_push", lvl_p4, 16);
        chk("pushpop_ovf", ovf, 0);
        chk("pushpop_head", dout, 32'h01020202);
        rd_en = 1'b1; tick(15); rd_en = 1'b0;
        chk("tail_is_new_frame", dout, 32'h0F0FF0F0);
        chk("tail_level", level, 1);
        rd_en = 1'b1; tick(2); rd_en = 1'b0;
        chk("pop_when_empty_level", level, 0);
        chk("pop_when_empty_flag", empty, 1);

        // reset in the middle of a right word
        for (int i = 0; i < 21; i++)
            sclk_cycle(i < 16, 1'b1);
        reset = 1'b1; tick(2); reset = 1'b0; tick(2);
        chk("midrst_level", level, 0);
        prev_lsb = 1'b1;
        send_frame(16'h0001, 16'h0002);
        flush();
        chk("midrst_first_dout", dout, 32'h00010002);
        chk("midrst_level_after", level, 1);

        // peak meters
        peak_clr = 1'b1; tick(1); peak_clr = 1'b0;
        send_frame(16'h8000, 16'h0100);
        flush();
`ifdef I2S_RX_PEAK_EN
        chk("peak_l_sat", peak_l, 15'h7FFF);
        chk("peak_r", peak_r, 15'h0100);
`else
        chk("peak_l_off", peak_l, 0);
        chk("peak_r_off", peak_r, 0);
`endif
        chk("peak_frame_level", level, 2);
        peak_clr = 1'b1; tick(1); peak_clr = 1'b0;
        chk("peak_l_clr", peak_l, 0);
        chk("peak_r_clr", peak_r, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
